// File: rtl/turing_step_sequencer.sv
// Step controller for the dumb-Turing core: runs one machine step as
// read, rule lookup, write, move, then updates head/state/count/flags.
module turing_step_sequencer #(
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned STATE_W   = 3,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned HEAD_INIT = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_STEPS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_run,
    input  logic               cmd_step,
    input  logic               cmd_stop,
    input  logic               cmd_clear,
    output logic [ADDR_W-1:0]  tape_addr,
    output logic               tape_we,
    output logic [SYM_W-1:0]   tape_wdata,
    input  logic [SYM_W-1:0]   tape_rdata,
    output logic [STATE_W-1:0] rule_state,
    output logic [SYM_W-1:0]   rule_sym,
    input  logic [STATE_W-1:0] rule_next,
    input  logic [SYM_W-1:0]   rule_wsym,
    input  logic               rule_right,
    input  logic               rule_halt,
    output logic [ADDR_W-1:0]  head_pos,
    output logic [STATE_W-1:0] cur_state,
    output logic [CNT_W-1:0]   step_count,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic               timeout,
    output logic               step_done
);

    typedef enum logic [2:0] {IDLE, READ, LOOK, WRITE, MOVE, HALT} fsm_t;

    localparam logic [ADDR_W-1:0] HEAD_RST  = ADDR_W'(HEAD_INIT);
    localparam logic [ADDR_W-1:0] HEAD_MAX  = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_STEPS);

    fsm_t               fsm, fsm_nxt;
    logic [SYM_W-1:0]   sym_reg, sym_nxt;
    logic               move_right, right_nxt;
    logic               stop_pend, pend_nxt;
    logic [ADDR_W-1:0]  head_nxt;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   cnt_nxt, cnt_inc;
    logic               halted_nxt, fault_nxt, timeout_nxt;
    logic               we_c, done_c, out_of_bounds;

    assign cnt_inc       = (step_count == {CNT_W{1'b1}}) ? step_count : step_count + CNT_W'(1);
    assign out_of_bounds = move_right ? (head_pos == HEAD_MAX) : (head_pos == '0);

    assign busy       = (fsm != IDLE) && (fsm != HALT);
    assign tape_addr  = head_pos;
    assign tape_wdata = rule_wsym;
    assign rule_state = cur_state;
    assign rule_sym   = sym_reg;
    // A step that is interrupted by reset must not leave a write or a done pulse behind.
    assign tape_we    = we_c & ~rst;
    assign step_done  = done_c & ~rst;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned,
        // which would otherwise infer a latch.
        fsm_nxt     = fsm;
        head_nxt    = head_pos;
        state_nxt   = cur_state;
        cnt_nxt     = step_count;
        sym_nxt     = sym_reg;
        right_nxt   = move_right;
        pend_nxt    = stop_pend;
        halted_nxt  = halted;
        fault_nxt   = fault;
        timeout_nxt = timeout;
        we_c        = 1'b0;
        done_c      = 1'b0;

        if (busy && cmd_stop) pend_nxt = 1'b1;

        unique case (fsm)
            IDLE: begin
                pend_nxt = 1'b0;
                if (cmd_clear) begin
                    head_nxt    = HEAD_RST;
                    state_nxt   = '0;
                    cnt_nxt     = '0;
                    halted_nxt  = 1'b0;
                    fault_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                end else if (cmd_run || cmd_step) begin
                    fsm_nxt = READ;
                end
            end
            READ: fsm_nxt = LOOK;
            LOOK: begin
                sym_nxt = tape_rdata;
                fsm_nxt = WRITE;
            end
            WRITE: begin
                we_c      = 1'b1;
                state_nxt = rule_next;
                right_nxt = rule_right;
                if (rule_halt) begin
                    cnt_nxt    = cnt_inc;
                    done_c     = 1'b1;
                    halted_nxt = 1'b1;
                    pend_nxt   = 1'b0;
                    fsm_nxt    = HALT;
                end else begin
                    fsm_nxt = MOVE;
                end
            end
            MOVE: begin
                if (out_of_bounds) begin
                    fault_nxt  = 1'b1;
                    halted_nxt = 1'b1;
                    pend_nxt   = 1'b0;
                    fsm_nxt    = HALT;
                end else begin
                    head_nxt = move_right ? head_pos + ADDR_W'(1) : head_pos - ADDR_W'(1);
                    cnt_nxt  = cnt_inc;
                    done_c   = 1'b1;
                    pend_nxt = 1'b0;
                    if (MAX_STEPS != 0 && cnt_inc == CNT_LIMIT) begin
                        timeout_nxt = 1'b1;
                        halted_nxt  = 1'b1;
                        fsm_nxt     = HALT;
                    end else if (stop_pend || cmd_stop || !cmd_run) begin
                        fsm_nxt = IDLE;
                    end else begin
                        fsm_nxt = READ;
                    end
                end
            end
            HALT: begin
                pend_nxt = 1'b0;
                if (cmd_clear) begin
                    head_nxt    = HEAD_RST;
                    state_nxt   = '0;
                    cnt_nxt     = '0;
                    halted_nxt  = 1'b0;
                    fault_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                    fsm_nxt     = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values computed above, independent of statement order.
        if (rst) begin
            fsm        <= IDLE;
            head_pos   <= HEAD_RST;
            cur_state  <= '0;
            step_count <= '0;
            sym_reg    <= '0;
            move_right <= 1'b0;
            stop_pend  <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            fsm        <= fsm_nxt;
            head_pos   <= head_nxt;
            cur_state  <= state_nxt;
            step_count <= cnt_nxt;
            sym_reg    <= sym_nxt;
            move_right <= right_nxt;
            stop_pend  <= pend_nxt;
            halted     <= halted_nxt;
            fault      <= fault_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_turing_step_sequencer.sv
// Directed bench: step vectors from a table, then busy-beaver run, edge fault,
// stop/run race, count saturation, reset during write and step-limit timeout.
module tb_turing_step_sequencer;

    typedef struct packed {
        logic [2:0] nxt;
        logic [1:0] wsym;
        logic       right;
        logic       halt;
    } rule_t;

    typedef struct {
        rule_t      r;
        logic [3:0] head;
        logic [2:0] st;
        logic [7:0] cnt;
        logic       hlt;
        logic [2:0] key_st;
        logic [1:0] key_sym;
        logic [3:0] cell_addr;
        logic [1:0] cell_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst, ram_clr, mon_clr;
    always #5 clk = ~clk;

    rule_t rules [32];

    logic       cmd_run_a, cmd_step_a, cmd_stop_a, cmd_clear_a;
    logic [3:0] tape_addr_a, head_pos_a;
    logic       tape_we_a, rule_right_a, rule_halt_a;
    logic [1:0] tape_wdata_a, tape_rdata_a, rule_sym_a, rule_wsym_a;
    logic [2:0] rule_state_a, rule_next_a, cur_state_a;
    logic [7:0] step_count_a;
    logic       busy_a, halted_a, fault_a, timeout_a, step_done_a;

    logic       cmd_run_b, cmd_step_b, cmd_stop_b, cmd_clear_b;
    logic [3:0] tape_addr_b, head_pos_b;
    logic       tape_we_b, rule_right_b, rule_halt_b;
    logic [1:0] tape_wdata_b, tape_rdata_b, rule_sym_b, rule_wsym_b;
    logic [2:0] rule_state_b, rule_next_b, cur_state_b;
    logic [7:0] step_count_b;
    logic       busy_b, halted_b, fault_b, timeout_b, step_done_b;

    assign {rule_next_a, rule_wsym_a, rule_right_a, rule_halt_a} = rules[{rule_state_a, rule_sym_a}];
    assign {rule_next_b, rule_wsym_b, rule_right_b, rule_halt_b} = rules[{rule_state_b, rule_sym_b}];

    turing_step_sequencer dut (
        .clk(clk), .rst(rst), .cmd_run(cmd_run_a), .cmd_step(cmd_step_a),
        .cmd_stop(cmd_stop_a), .cmd_clear(cmd_clear_a), .tape_addr(tape_addr_a),
        .tape_we(tape_we_a), .tape_wdata(tape_wdata_a), .tape_rdata(tape_rdata_a),
        .rule_state(rule_state_a), .rule_sym(rule_sym_a), .rule_next(rule_next_a),
        .rule_wsym(rule_wsym_a), .rule_right(rule_right_a), .rule_halt(rule_halt_a),
        .head_pos(head_pos_a), .cur_state(cur_state_a), .step_count(step_count_a),
        .busy(busy_a), .halted(halted_a), .fault(fault_a), .timeout(timeout_a),
        .step_done(step_done_a)
    );

    turing_step_sequencer #(.MAX_STEPS(5)) dut_lim (
        .clk(clk), .rst(rst), .cmd_run(cmd_run_b), .cmd_step(cmd_step_b),
        .cmd_stop(cmd_stop_b), .cmd_clear(cmd_clear_b), .tape_addr(tape_addr_b),
        .tape_we(tape_we_b), .tape_wdata(tape_wdata_b), .tape_rdata(tape_rdata_b),
        .rule_state(rule_state_b), .rule_sym(rule_sym_b), .rule_next(rule_next_b),
        .rule_wsym(rule_wsym_b), .rule_right(rule_right_b), .rule_halt(rule_halt_b),
        .head_pos(head_pos_b), .cur_state(cur_state_b), .step_count(step_count_b),
        .busy(busy_b), .halted(halted_b), .fault(fault_b), .timeout(timeout_b),
        .step_done(step_done_b)
    );

    // Tape RAMs: synchronous read, write-first not needed since reads and writes never share a cycle.
    logic [1:0] mem_a [16];
    logic [1:0] mem_b [16];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (tape_we_a) mem_a[tape_addr_a] <= tape_wdata_a;
            if (tape_we_b) mem_b[tape_addr_b] <= tape_wdata_b;
        end
        tape_rdata_a <= mem_a[tape_addr_a];
        tape_rdata_b <= mem_b[tape_addr_b];
    end

    int         cyc = 0;
    int         done_a, we_a, gap_bad, last_we, done_b;
    logic [2:0] key_st;
    logic [1:0] key_sym;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            done_a <= 0; we_a <= 0; gap_bad <= 0; last_we <= 0; done_b <= 0;
        end else begin
            if (step_done_a) done_a <= done_a + 1;
            if (step_done_b) done_b <= done_b + 1;
            if (tape_we_a) begin
                we_a    <= we_a + 1;
                key_st  <= rule_state_a;
                key_sym <= rule_sym_a;
                if (we_a != 0 && cyc - last_we != 4) gap_bad <= gap_bad + 1;
                last_we <= cyc;
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic bound_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic set_all(input rule_t r);
        for (int i = 0; i < 32; i++) rules[i] = r;
    endtask

    task automatic wait_idle_a(input int budget, input string name);
        for (int i = 0; i < budget && busy_a; i++) @(negedge clk);
        if (busy_a) bound_fail(name);
    endtask

    task automatic pulse_clear_a();
        @(negedge clk) cmd_clear_a = 1'b1;
        @(negedge clk) cmd_clear_a = 1'b0;
    endtask

    task automatic pulse_mon_clr();
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) mon_clr = 1'b0;
    endtask

    task automatic pulse_ram_clr();
        @(negedge clk) ram_clr = 1'b1;
        @(negedge clk) ram_clr = 1'b0;
    endtask

    task automatic set_oscillate();
        set_all('{nxt: 3'd0, wsym: 2'd0, right: 1'b1, halt: 1'b1});
        for (int i = 0; i < 4; i++) rules[i]     = '{nxt: 3'd1, wsym: 2'd0, right: 1'b1, halt: 1'b0};
        for (int i = 4; i < 8; i++) rules[i]     = '{nxt: 3'd0, wsym: 2'd0, right: 1'b0, halt: 1'b0};
    endtask

    vec_t        vecs [4];
    logic [31:0] img, exp_img;
    int          d0, w0, seen;
    bit          hit;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{r: '{3'd1, 2'd1, 1'b1, 1'b0}, head: 4'd9, st: 3'd1, cnt: 8'd1, hlt: 1'b0,
                    key_st: 3'd0, key_sym: 2'd0, cell_addr: 4'd8, cell_val: 2'd1};
        vecs[1] = '{r: '{3'd2, 2'd2, 1'b0, 1'b0}, head: 4'd8, st: 3'd2, cnt: 8'd2, hlt: 1'b0,
                    key_st: 3'd1, key_sym: 2'd0, cell_addr: 4'd9, cell_val: 2'd2};
        vecs[2] = '{r: '{3'd3, 2'd3, 1'b0, 1'b0}, head: 4'd7, st: 3'd3, cnt: 8'd3, hlt: 1'b0,
                    key_st: 3'd2, key_sym: 2'd1, cell_addr: 4'd8, cell_val: 2'd3};
        vecs[3] = '{r: '{3'd5, 2'd1, 1'b1, 1'b1}, head: 4'd7, st: 3'd5, cnt: 8'd4, hlt: 1'b1,
                    key_st: 3'd3, key_sym: 2'd0, cell_addr: 4'd7, cell_val: 2'd1};

        rst = 1'b1; ram_clr = 1'b1; mon_clr = 1'b1;
        {cmd_run_a, cmd_step_a, cmd_stop_a, cmd_clear_a} = '0;
        {cmd_run_b, cmd_step_b, cmd_stop_b, cmd_clear_b} = '0;
        set_all('{nxt: 3'd0, wsym: 2'd0, right: 1'b1, halt: 1'b1});
        repeat (3) @(negedge clk);
        rst = 1'b0; ram_clr = 1'b0; mon_clr = 1'b0;

        check("rst_head", head_pos_a, 8);
        check("rst_state", cur_state_a, 0);
        check("rst_count", step_count_a, 0);
        check("rst_flags", {busy_a, halted_a, fault_a, timeout_a, tape_we_a, step_done_a}, 0);
        check("rst_addr", tape_addr_a, 8);

        // Single steps from the table, each with its own uniform rule.
        foreach (vecs[k]) begin
            set_all(vecs[k].r);
            d0 = done_a; w0 = we_a;
            @(negedge clk) cmd_step_a = 1'b1;
            @(negedge clk) cmd_step_a = 1'b0;
            wait_idle_a(10, $sformatf("v%0d_idle", k));
            check($sformatf("v%0d_head", k), head_pos_a, vecs[k].head);
            check($sformatf("v%0d_state", k), cur_state_a, vecs[k].st);
            check($sformatf("v%0d_count", k), step_count_a, vecs[k].cnt);
            check($sformatf("v%0d_halted", k), halted_a, vecs[k].hlt);
            check($sformatf("v%0d_key_state", k), key_st, vecs[k].key_st);
            check($sformatf("v%0d_key_sym", k), key_sym, vecs[k].key_sym);
            check($sformatf("v%0d_cell", k), mem_a[vecs[k].cell_addr], vecs[k].cell_val);
            check($sformatf("v%0d_done_pulses", k), done_a - d0, 1);
            check($sformatf("v%0d_writes", k), we_a - w0, 1);
        end

        // Run/step ignored while halted, clear reloads but leaves the tape alone.
        @(negedge clk) cmd_step_a = 1'b1; cmd_run_a = 1'b1;
        @(negedge clk) cmd_step_a = 1'b0; cmd_run_a = 1'b0;
        check("halt_ignores_run", {busy_a, halted_a}, 2'b01);
        pulse_clear_a();
        check("clr_head", head_pos_a, 8);
        check("clr_state", cur_state_a, 0);
        check("clr_count", step_count_a, 0);
        check("clr_flags", {busy_a, halted_a, fault_a, timeout_a}, 0);
        check("clr_tape8", mem_a[8], 3);
        check("clr_tape9", mem_a[9], 2);

        // 3-state busy beaver: 14 steps, six ones on cells 7..12, halts at head 9.
        pulse_ram_clr();
        set_all('{nxt: 3'd7, wsym: 2'd0, right: 1'b1, halt: 1'b1});
        rules[0] = '{3'd1, 2'd1, 1'b1, 1'b0};
        rules[1] = '{3'd3, 2'd1, 1'b1, 1'b1};
        rules[4] = '{3'd2, 2'd0, 1'b1, 1'b0};
        rules[5] = '{3'd1, 2'd1, 1'b1, 1'b0};
        rules[8] = '{3'd2, 2'd1, 1'b0, 1'b0};
        rules[9] = '{3'd0, 2'd1, 1'b0, 1'b0};
        pulse_mon_clr();
        @(negedge clk) cmd_run_a = 1'b1;
        for (int i = 0; i < 200 && !halted_a; i++) @(negedge clk);
        if (!halted_a) bound_fail("bb_halt");
        cmd_run_a = 1'b0;
        img = '0; exp_img = '0;
        for (int i = 0; i < 16; i++) img[2*i +: 2] = mem_a[i];
        for (int i = 7; i <= 12; i++) exp_img[2*i] = 1'b1;
        check("bb_halted", {halted_a, fault_a, timeout_a, busy_a}, 4'b1000);
        check("bb_head", head_pos_a, 9);
        check("bb_state", cur_state_a, 3);
        check("bb_count", step_count_a, 14);
        check("bb_done_pulses", done_a, 14);
        check("bb_writes", we_a, 14);
        check("bb_gaps", gap_bad, 0);
        check("bb_tape", img, exp_img);

        // Left edge: eight left moves reach cell 0, the ninth faults after writing.
        pulse_clear_a();
        set_all('{nxt: 3'd0, wsym: 2'd2, right: 1'b0, halt: 1'b0});
        pulse_mon_clr();
        @(negedge clk) cmd_run_a = 1'b1;
        for (int i = 0; i < 100 && !halted_a; i++) @(negedge clk);
        if (!halted_a) bound_fail("fault_halt");
        cmd_run_a = 1'b0;
        check("fault_flags", {halted_a, fault_a, timeout_a}, 3'b110);
        check("fault_head", head_pos_a, 0);
        check("fault_count", step_count_a, 8);
        check("fault_done_pulses", done_a, 8);
        check("fault_writes", we_a, 9);
        check("fault_cell0", mem_a[0], 2);

        // Stop alone in IDLE, then stop together with run in LOOK of the third step.
        pulse_clear_a();
        set_oscillate();
        pulse_mon_clr();
        @(negedge clk) cmd_stop_a = 1'b1;
        @(negedge clk) cmd_stop_a = 1'b0;
        check("stop_idle_noop", busy_a, 0);
        cmd_run_a = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            if (step_done_a) seen++;
        end
        if (seen < 2) bound_fail("stop_two_steps");
        @(negedge clk);
        @(negedge clk) cmd_stop_a = 1'b1;
        @(negedge clk) cmd_stop_a = 1'b0;
        @(negedge clk);
        check("stop_step_completes", step_done_a, 1);
        @(negedge clk);
        check("stop_goes_idle", busy_a, 0);
        cmd_run_a = 1'b0;
        repeat (8) @(negedge clk);
        check("stop_no_more_writes", we_a, 3);
        check("stop_count", step_count_a, 3);
        check("stop_head", head_pos_a, 9);
        check("stop_state", cur_state_a, 1);

        // Count saturates at 255 when run long enough.
        pulse_clear_a();
        @(negedge clk) cmd_run_a = 1'b1;
        seen = 0;
        for (int i = 0; i < 1400 && seen < 260; i++) begin
            @(negedge clk);
            if (step_done_a) seen++;
        end
        if (seen < 260) bound_fail("sat_steps");
        cmd_run_a = 1'b0;
        wait_idle_a(10, "sat_idle");
        check("sat_count", step_count_a, 255);
        check("sat_flags", {halted_a, fault_a, timeout_a}, 0);

        // Reset asserted during WRITE: write strobe suppressed, IDLE afterwards.
        pulse_ram_clr();
        pulse_clear_a();
        set_all('{nxt: 3'd1, wsym: 2'd3, right: 1'b1, halt: 1'b0});
        @(negedge clk) cmd_step_a = 1'b1;
        @(negedge clk) cmd_step_a = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (tape_we_a) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) bound_fail("rst_wait_write");
        rst = 1'b1;
        #1;
        check("rst_write_we", tape_we_a, 0);
        @(negedge clk) rst = 1'b0;
        check("rst_write_idle", busy_a, 0);
        check("rst_write_head", head_pos_a, 8);
        check("rst_write_cell", mem_a[8], 0);

        // Step limit of 5 on the second instance.
        set_oscillate();
        pulse_mon_clr();
        @(negedge clk) cmd_run_b = 1'b1;
        for (int i = 0; i < 100 && !halted_b; i++) @(negedge clk);
        if (!halted_b) bound_fail("to_halt");
        cmd_run_b = 1'b0;
        check("to_flags", {halted_b, timeout_b, fault_b, busy_b}, 4'b1100);
        check("to_count", step_count_b, 5);
        check("to_done_pulses", done_b, 5);
        check("to_head", head_pos_b, 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/turing_step_sequencer.md
Name: turing_step_sequencer

Overview:
- Step controller for the dumb-Turing core: sequences one machine step as tape read, rule lookup, tape write, head move and state update.
- Accepts run/step/stop/clear commands decoded from the top-level pins.
- Drives the single-port tape RAM and the combinational rule-table lookup.
- Reports head position, machine state, step count and halt/fault status to the output mux.

Parameters:
- SYM_W, 2, tape symbol width in bits.
- STATE_W, 3, machine state register width.
- ADDR_W, 4, tape address width; tape length is 2**ADDR_W cells.
- HEAD_INIT, 8, head position loaded on reset and on clear.
- CNT_W, 8, step counter width.
- MAX_STEPS, 0, step limit; 0 means unlimited.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_run  in  1  level: step continuously while high.
- cmd_step  in  1  pulse: execute exactly one step.
- cmd_stop  in  1  pulse: stop at the end of the current step.
- cmd_clear  in  1  pulse: reset head, state, count and flags (tape untouched).
- tape_addr  out  ADDR_W  tape RAM address; always equals head_pos.
- tape_we  out  1  tape write strobe.
- tape_wdata  out  SYM_W  symbol to write.
- tape_rdata  in  SYM_W  RAM read data, valid one cycle after the address.
- rule_state  out  STATE_W  lookup key: current state.
- rule_sym  out  SYM_W  lookup key: latched symbol.
- rule_next  in  STATE_W  rule next state (combinational from the keys).
- rule_wsym  in  SYM_W  rule symbol to write.
- rule_right  in  1  rule move direction: 1 = right (+1), 0 = left (-1).
- rule_halt  in  1  rule is a halt rule.
- head_pos  out  ADDR_W  current head position.
- cur_state  out  STATE_W  current machine state.
- step_count  out  CNT_W  completed steps.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  machine is in HALT.
- fault  out  1  head tried to leave the tape.
- timeout  out  1  MAX_STEPS was reached.
- step_done  out  1  one-cycle pulse when a step completes.

Behaviour:
- Reset values: FSM=IDLE, head_pos=HEAD_INIT, cur_state=0, step_count=0. All flags and strobes are 0. sym_reg=0.
- FSM states: IDLE, READ, LOOK, WRITE, MOVE, HALT. A normal step takes 4 cycles (READ->LOOK->WRITE->MOVE).
- IDLE:
  - cmd_clear has priority: reload head/state/count, clear flags, stay in IDLE.
  - Otherwise cmd_run or cmd_step -> READ.
  - cmd_stop alone has no effect.
- READ: tape_addr=head_pos; the RAM registers the read.
- LOOK: sym_reg <= tape_rdata.
  - rule_state=cur_state and rule_sym=sym_reg are held from LOOK through WRITE.
- WRITE:
  - tape_we=1, tape_wdata=rule_wsym.
  - cur_state <= rule_next.
  - Latch rule_right into a move register.
  - If rule_halt: step_count++, step_done=1, halted=1, next state HALT (no move).
  - Otherwise next state MOVE.
- MOVE, boundary case: if rule_right and head_pos is at max, or !rule_right and head_pos is 0, the move is out of bounds.
  - head_pos is unchanged, fault=1, next state HALT.
  - step_count is not incremented and step_done is not pulsed.
- MOVE, normal case: head_pos ±1, step_count++, step_done=1.
  - If MAX_STEPS≠0 and the new count equals MAX_STEPS: timeout=1, halted=1, next state HALT.
  - Else if a stop is pending, or cmd_run is low: next state IDLE.
  - Else next state READ (back-to-back steps, no bubble).
- Stop handling:
  - cmd_stop in any busy state sets a pending flag.
  - The pending flag is cleared on entry to IDLE or HALT.
  - Stop beats run in the same cycle.
- step_count saturates at all-ones and never wraps.
- HALT:
  - Ignores run, step and stop.
  - cmd_clear -> IDLE with a full reload.
  - halted stays 1 until clear.
- cmd_step/cmd_clear pulses arriving while busy: step is ignored; clear is ignored.
- tape_we is high only in WRITE, exactly one cycle per step.
- Reset mid-step: returns to IDLE next cycle. The tape is not written in the reset cycle, because tape_we is forced to 0.

Test Plan:
- Single step: rule (s0, sym0) -> write 1, right, s1; cmd_step from reset -> writes 1 at addr 8, head=9, state=1, count=1, step_done pulsed in cycle 4, back to IDLE.
- Continuous run: 3-state busy-beaver rule table, cmd_run held -> one step every 4 cycles with no gaps; halt rule reached -> halted=1, final write performed, head not moved, count matches the reference trace.
- Left-edge fault: head=0 with a left-moving rule -> fault=1, halted=1, head stays 0, count unchanged, tape cell 0 still written.
- Stop and run together: cmd_stop and cmd_run in the same cycle mid-step -> the current step completes, then IDLE; no further READ.
- Timeout: MAX_STEPS=5, non-halting rule, run -> timeout=1, halted=1 after exactly 5 step_done pulses, count=5.
- Clear and reset: clear while halted -> head=8, state=0, count=0, flags 0, tape contents preserved; rst asserted during WRITE -> no tape_we, IDLE next cycle.
